// File: rtl/video_timing_if.sv
// Raster timing bundle between the timing generator and its consumers.
// The master drives position, enables and syncs; the slave drives en.
interface video_timing_if;
  logic        en;
  logic [15:0] x;
  logic [15:0] y;
  logic        vde;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;

  modport master (
    input  en,
    output x, y, vde, hsync, vsync,
    output line_start, frame_start
  );

  modport slave (
    output en,
    input  x, y, vde, hsync, vsync,
    input  line_start, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: h/v counters decoded into
// registered position, data enable, syncs and line/frame pulses.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  video_timing_if.master vt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_bad_size
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 16 bits");
  end

  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] hc_q, hc_d;
  logic [15:0] vc_q, vc_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        vde_q, vde_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic        hs_on, vs_on;

  assign hs_on = (hc_q >= HS_BEG) && (hc_q < HS_END);
  assign vs_on = (vc_q >= VS_BEG) && (vc_q < VS_END);

  always_comb begin
    hc_d  = hc_q;
    vc_d  = vc_q;
    x_d   = x_q;
    y_d   = y_q;
    vde_d = vde_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    if (vt.en) begin
      x_d   = hc_q;
      y_d   = vc_q;
      vde_d = (hc_q < H_ACT) && (vc_q < V_ACT);
      hs_d  = hs_on ? HS_POL : ~HS_POL;
      vs_d  = vs_on ? VS_POL : ~VS_POL;
      ls_d  = (hc_q == '0);
      fs_d  = (hc_q == '0) && (vc_q == '0);
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 16'd1;
      end else begin
        hc_d = hc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q  <= '0;
      vc_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      vde_q <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      vde_q <= vde_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign vt.x           = x_q;
  assign vt.y           = y_q;
  assign vt.vde         = vde_q;
  assign vt.hsync       = hs_q;
  assign vt.vsync       = vs_q;
  assign vt.line_start  = ls_q;
  assign vt.frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small-frame builds with both sync
// polarities, vector table, corner sequences and a random run.
module tb_video_timing_gen;
  localparam int HA = 8, HF = 2, HS = 2, HB = 4;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  video_timing_if vif ();
  video_timing_if vin ();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .vt(vif.master)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_inv (
    .clk(clk), .rst(rst), .vt(vin.master)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: position is just the count of enabled cycles mod frame size
  int          pos;
  logic [15:0] mx, my;
  logic        mvde, mhs, mvs, mls, mfs;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_step(bit r, bit e);
    int px, py;
    if (r) begin
      pos = 0;
      mx = '0; my = '0;
      mvde = 0; mhs = 0; mvs = 0; mls = 0; mfs = 0;
    end else if (e) begin
      px   = pos % HT;
      py   = pos / HT;
      mx   = 16'(px);
      my   = 16'(py);
      mvde = (px < HA) && (py < VA);
      mhs  = (px >= HA + HF) && (px < HA + HF + HS);
      mvs  = (py >= VA + VF) && (py < VA + VF + VS);
      mls  = (px == 0);
      mfs  = (pos == 0);
      pos  = (pos + 1) % FT;
    end else begin
      mls = 0;
      mfs = 0;
    end
  endtask

  task automatic cycle(bit r, bit e);
    rst    = r;
    vif.en = e;
    vin.en = e;
    @(posedge clk);
    #1;
    model_step(r, e);
    check("model_pos", 64'({vif.x, vif.y, vif.vde, vif.hsync, vif.vsync,
                            vif.line_start, vif.frame_start}),
                       64'({mx, my, mvde, mhs, mvs, mls, mfs}));
    check("model_inv", 64'({vin.x, vin.y, vin.vde, vin.hsync, vin.vsync,
                            vin.line_start, vin.frame_start}),
                       64'({mx, my, mvde, ~mhs, ~mvs, mls, mfs}));
  endtask

  typedef struct {
    bit          rst;
    bit          en;
    logic [15:0] x;
    logic [15:0] y;
    bit          vde;
    bit          hs;
    bit          vs;
    bit          ls;
    bit          fs;
  } vec_t;

  vec_t vecs[10];

  int c_vde, c_fs, c_hs, c_vs, c_ls;

  initial begin
    rst    = 1'b1;
    vif.en = 1'b0;
    vin.en = 1'b0;
    pos    = 0;

    vecs[0] = '{1, 1, 16'd0, 16'd0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 1, 16'd0, 16'd0, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 1, 16'd0, 16'd0, 1, 0, 0, 1, 1};
    vecs[3] = '{0, 1, 16'd1, 16'd0, 1, 0, 0, 0, 0};
    vecs[4] = '{0, 0, 16'd1, 16'd0, 1, 0, 0, 0, 0};
    vecs[5] = '{0, 0, 16'd1, 16'd0, 1, 0, 0, 0, 0};
    vecs[6] = '{0, 1, 16'd2, 16'd0, 1, 0, 0, 0, 0};
    vecs[7] = '{0, 1, 16'd3, 16'd0, 1, 0, 0, 0, 0};
    vecs[8] = '{1, 0, 16'd0, 16'd0, 0, 0, 0, 0, 0};
    vecs[9] = '{0, 1, 16'd0, 16'd0, 1, 0, 0, 1, 1};

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].rst, vecs[i].en);
      check($sformatf("vec%0d", i),
            64'({vif.x, vif.y, vif.vde, vif.hsync, vif.vsync,
                 vif.line_start, vif.frame_start}),
            64'({vecs[i].x, vecs[i].y, vecs[i].vde, vecs[i].hs,
                 vecs[i].vs, vecs[i].ls, vecs[i].fs}));
    end

    // Free run over one frame plus one cycle
    cycle(1, 0);
    c_vde = 0; c_fs = 0; c_hs = 0; c_vs = 0; c_ls = 0;
    for (int i = 0; i < FT + 1; i++) begin
      cycle(0, 1);
      if (i < FT) begin
        c_vde += int'(vif.vde);
        c_hs  += int'(vif.hsync);
        c_vs  += int'(vif.vsync);
        c_ls  += int'(vif.line_start);
        if (vif.hsync && !(vif.x == 16'd10 || vif.x == 16'd11))
          check("hs_pos", 64'(vif.x), 64'd10);
        if (vif.vsync) check("vs_line", 64'(vif.y), 64'd5);
      end
      c_fs += int'(vif.frame_start);
    end
    check("vde_cnt", 64'(c_vde), 64'(HA * VA));
    check("hs_cnt", 64'(c_hs), 64'(HS * VT));
    check("vs_cnt", 64'(c_vs), 64'(VS * HT));
    check("ls_cnt", 64'(c_ls), 64'(VT));
    check("fs_cnt", 64'(c_fs), 64'd2);

    // Pause at the last pixel of the frame
    cycle(1, 0);
    for (int i = 0; i < FT; i++) cycle(0, 1);
    check("end_xy", 64'({vif.x, vif.y}), 64'({16'd15, 16'd7}));
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0);
      check("hold_xy", 64'({vif.x, vif.y}), 64'({16'd15, 16'd7}));
      check("hold_pulse", 64'({vif.line_start, vif.frame_start}), 64'd0);
    end
    cycle(0, 1);
    check("resume", 64'({vif.x, vif.y, vif.frame_start}),
                    64'({16'd0, 16'd0, 1'b1}));
    cycle(0, 1);
    check("resume_once", 64'(vif.frame_start), 64'd0);

    // Reset in mid-frame
    cycle(1, 0);
    for (int i = 0; i < 3 * HT + 7; i++) cycle(0, 1);
    check("mid_xy", 64'({vif.x, vif.y}), 64'({16'd6, 16'd3}));
    cycle(1, 1);
    check("mid_rst", 64'({vif.x, vif.y, vif.vde, vif.frame_start}), 64'd0);
    cycle(0, 1);
    check("mid_restart", 64'({vif.x, vif.y, vif.frame_start}),
                         64'({16'd0, 16'd0, 1'b1}));

    // Random enable pattern with rare resets
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
